mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Two-port arbiter and sequencer for the shared memory bus: 32-bit address, 64-bit data, with RAM/ROM/PERIF/UNUSED chip selects. It sits between the control unit's load/store and fetch port (CPU) and a second bus master (DMA/peripheral engine). The winning requester gets exclusive use of the bus for one transaction. The block decodes the address into a chip select, inserts per-region wait states, and returns read data with a one-cycle acknowledge.

## Interface
- RAM_WAIT, 0: extra wait cycles for a RAM access
- ROM_WAIT, 1: extra wait cycles for a ROM access
- PERIF_WAIT, 2: extra wait cycles for a PERIF access (all wait parameters 0..15)

- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- cpu_req / dma_req  in  1  transaction request; held with its qualifiers until the matching ack
- cpu_write / dma_write  in  1  1 = write, 0 = read
- cpu_addr / dma_addr  in  32  byte address
- cpu_wdata / dma_wdata  in  64  write data
- cpu_size / dma_size  in  2  access size, passed through to mem_size
- cpu_ack / dma_ack  out  1  one-cycle completion pulse
- cpu_rdata / dma_rdata  out  64  read data, valid in the ack cycle and held until that port's next read completes
- mem_address  out  32  bus address
- mem_wdata  out  64  bus write data
- mem_rdata  in  64  bus read data
- mem_read, mem_write_en  out  1  bus strobes
- mem_size  out  2  bus access size
- ROM_select, RAM_select, PERIF_select, UNUSED_select  out  1  one-hot region select
- bus_error  out  1  one-cycle pulse, coincident with ack, on an illegal access

## Operation
- Address decode on addr[31:28]:
  - 0x0 = ROM
  - 0x1 = RAM
  - 0x2 = PERIF
  - any other value = UNUSED
- FSM states:
  - IDLE: any req present → GRANT latches the owner, address, data, size, write, region and the wait count for that region; go to ACCESS. No req → stay in IDLE.
  - ACCESS: drive the bus from the latched values. Count down the wait counter. When the counter is 0, capture mem_rdata and go to RESP.
  - RESP: pulse the owner's ack (plus bus_error if applicable), then go to IDLE.
- Bus signals are driven only in ACCESS. In IDLE and RESP all selects and strobes are 0, mem_address is 0 and mem_wdata is 0.
- Owner inputs are sampled only at grant. Changes to them afterwards are ignored.
- ROM write: mem_write_en is suppressed, the ROM_select timing is unchanged, ack is given, and bus_error pulses.
- UNUSED access:
  - UNUSED_select is asserted for one cycle with no wait states.
  - Strobes are suppressed.
  - Read data is 0 and bus_error pulses.
- A requester whose req drops before grant is never served. If req drops after grant, the transaction still completes and acks.
- Priority when both ports request in IDLE: the CPU always wins (baseline; see Configuration).

## Timing
- Reset (asynchronous, req ignored while low): state IDLE; all outputs 0, including both rdata registers, ack, bus_error and every select/strobe.
- reset asserted mid-transaction aborts immediately. The strobes fall asynchronously and no ack is issued.
- Latency, with req high in IDLE at edge N:
  - ACCESS occupies edges N+1 .. N+1+W, where W is the region's wait count (W = 0 for UNUSED).
  - ack is high for the cycle after edge N+2+W.
  - Request to ack is W+2 cycles.
- The requester may drop req in its ack cycle. If req is still high in IDLE, the next transaction starts.
- Minimum transaction spacing is W+3 cycles.
- The wait counter is 4 bits and loads the region's wait count in GRANT. The 0 check happens before the decrement, so the counter never wraps.

## Configuration
- ARB_ROUND_ROBIN_EN defined:
  - On a tie, the port not granted last wins.
  - A last_grant flop updates at every grant.
  - After reset, last_grant = DMA, so the CPU wins the first tie.
  - A single requester is always served regardless of last_grant.
- ARB_ROUND_ROBIN_EN undefined: fixed CPU priority and no last_grant flop. Continuous CPU requests may starve DMA.

## Test plan
- Reset: assert reset low with cpu_req=1 → all outputs 0, no ack. Release → CPU read of 0x1000_0008 starts at the next edge.
- CPU RAM read:
  - Stimulus: addr 0x1000_0010, RAM_WAIT=0, mem_rdata=0xDEAD_BEEF_0123_4567.
  - Response: RAM_select and mem_read high for 1 cycle; cpu_ack 2 cycles after req; cpu_rdata = 0xDEAD_BEEF_0123_4567.
- PERIF write by DMA:
  - Stimulus: addr 0x2000_0000, wdata 0x55.
  - Response: PERIF_select and mem_write_en high for 3 cycles; dma_ack at cycle 4; bus_error 0.
- Tie:
  - Stimulus: cpu_req and dma_req high together for 4 consecutive transactions.
  - Response without the macro: CPU,CPU,CPU,CPU.
  - Response with ARB_ROUND_ROBIN_EN: CPU,DMA,CPU,DMA.
- Errors:
  - CPU write to 0x0000_0040 → no mem_write_en; cpu_ack and bus_error coincident.
  - DMA read of 0x7000_0000 → UNUSED_select for 1 cycle; dma_rdata=0; bus_error pulse.
- Abort: assert reset mid-ACCESS of a ROM read → strobes drop at once, no cpu_ack; the next request after release completes normally.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: one requester port (CPU or DMA) of the shared memory bus arbiter.
// The requester drives master; the arbiter takes slave.
interface mem_bus_arbiter_if;
    logic        req;
    logic        write;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [1:0]  size;
    logic        ack;
    logic [63:0] rdata;

    modport master (output req, write, addr, wdata, size, input ack, rdata);
    modport slave  (input req, write, addr, wdata, size, output ack, rdata);
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: CPU/DMA arbiter and sequencer for the shared memory bus with region decode and wait states.
// Optional ARB_ROUND_ROBIN_EN: alternate the winner on ties instead of fixed CPU priority.
module mem_bus_arbiter #(
    parameter int unsigned RAM_WAIT   = 0,
    parameter int unsigned ROM_WAIT   = 1,
    parameter int unsigned PERIF_WAIT = 2
) (
    input  logic             clock,
    input  logic             reset,
    mem_bus_arbiter_if.slave cpu,
    mem_bus_arbiter_if.slave dma,
    output logic [31:0]      mem_address,
    output logic [63:0]      mem_wdata,
    input  logic [63:0]      mem_rdata,
    output logic             mem_read,
    output logic             mem_write_en,
    output logic [1:0]       mem_size,
    output logic             ROM_select,
    output logic             RAM_select,
    output logic             PERIF_select,
    output logic             UNUSED_select,
    output logic             bus_error
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    typedef enum logic [1:0] {REGION_ROM, REGION_RAM, REGION_PERIF, REGION_UNUSED} region_t;

    state_t      state;
    region_t     region_q;
    logic        owner_dma;
    logic        write_q;
    logic        error_q;
    logic [3:0]  wait_cnt;
    logic [63:0] rdata_q;
    logic [63:0] cpu_rdata_q;
    logic [63:0] dma_rdata_q;
    logic        cpu_ack_q;
    logic        dma_ack_q;

    logic        pick_dma;
    logic        sel_write;
    logic [31:0] sel_addr;
    logic [63:0] sel_wdata;
    logic [1:0]  sel_size;
    region_t     sel_region;
    logic [3:0]  sel_wait;

`ifdef ARB_ROUND_ROBIN_EN
    logic        last_grant_dma;
`endif

    // Winner selection and decode of the winner's qualifiers, consumed only at grant.
    always_comb begin
        pick_dma = dma.req && !cpu.req;
`ifdef ARB_ROUND_ROBIN_EN
        if (cpu.req && dma.req) begin
            pick_dma = !last_grant_dma;
        end
`endif
        sel_write = pick_dma ? dma.write : cpu.write;
        sel_addr  = pick_dma ? dma.addr  : cpu.addr;
        sel_wdata = pick_dma ? dma.wdata : cpu.wdata;
        sel_size  = pick_dma ? dma.size  : cpu.size;
        case (sel_addr[31:28])
            4'h0:    sel_region = REGION_ROM;
            4'h1:    sel_region = REGION_RAM;
            4'h2:    sel_region = REGION_PERIF;
            default: sel_region = REGION_UNUSED;
        endcase
        case (sel_region)
            REGION_ROM:   sel_wait = 4'(ROM_WAIT);
            REGION_RAM:   sel_wait = 4'(RAM_WAIT);
            REGION_PERIF: sel_wait = 4'(PERIF_WAIT);
            default:      sel_wait = 4'd0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            region_q      <= REGION_ROM;
            owner_dma     <= 1'b0;
            write_q       <= 1'b0;
            error_q       <= 1'b0;
            wait_cnt      <= 4'd0;
            rdata_q       <= 64'd0;
            cpu_rdata_q   <= 64'd0;
            dma_rdata_q   <= 64'd0;
            cpu_ack_q     <= 1'b0;
            dma_ack_q     <= 1'b0;
            bus_error     <= 1'b0;
            mem_address   <= 32'd0;
            mem_wdata     <= 64'd0;
            mem_read      <= 1'b0;
            mem_write_en  <= 1'b0;
            mem_size      <= 2'd0;
            ROM_select    <= 1'b0;
            RAM_select    <= 1'b0;
            PERIF_select  <= 1'b0;
            UNUSED_select <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_dma <= 1'b1;
`endif
        end else begin
            cpu_ack_q <= 1'b0;
            dma_ack_q <= 1'b0;
            bus_error <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu.req || dma.req) begin
                        owner_dma     <= pick_dma;
                        write_q       <= sel_write;
                        region_q      <= sel_region;
                        wait_cnt      <= sel_wait;
                        error_q       <= (sel_region == REGION_UNUSED) ||
                                         (sel_region == REGION_ROM && sel_write);
                        mem_address   <= sel_addr;
                        mem_wdata     <= sel_wdata;
                        mem_size      <= sel_size;
                        // ROM writes and UNUSED accesses keep their select but never strobe.
                        mem_read      <= !sel_write && (sel_region != REGION_UNUSED);
                        mem_write_en  <= sel_write &&
                                         (sel_region == REGION_RAM || sel_region == REGION_PERIF);
                        ROM_select    <= (sel_region == REGION_ROM);
                        RAM_select    <= (sel_region == REGION_RAM);
                        PERIF_select  <= (sel_region == REGION_PERIF);
                        UNUSED_select <= (sel_region == REGION_UNUSED);
`ifdef ARB_ROUND_ROBIN_EN
                        last_grant_dma <= pick_dma;
`endif
                        state         <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (wait_cnt == 4'd0) begin
                        rdata_q       <= (region_q == REGION_UNUSED) ? 64'd0 : mem_rdata;
                        mem_address   <= 32'd0;
                        mem_wdata     <= 64'd0;
                        mem_size      <= 2'd0;
                        mem_read      <= 1'b0;
                        mem_write_en  <= 1'b0;
                        ROM_select    <= 1'b0;
                        RAM_select    <= 1'b0;
                        PERIF_select  <= 1'b0;
                        UNUSED_select <= 1'b0;
                        state         <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (owner_dma) begin
                        dma_ack_q <= 1'b1;
                        if (!write_q) begin
                            dma_rdata_q <= rdata_q;
                        end
                    end else begin
                        cpu_ack_q <= 1'b1;
                        if (!write_q) begin
                            cpu_rdata_q <= rdata_q;
                        end
                    end
                    bus_error <= error_q;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign cpu.ack   = cpu_ack_q;
    assign cpu.rdata = cpu_rdata_q;
    assign dma.ack   = dma_ack_q;
    assign dma.rdata = dma_rdata_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed and randomized bursts against a transaction-level model,
// with a scoreboard queue checked by an independent negedge monitor.
module tb_mem_bus_arbiter;
    localparam int RAM_W   = 0;
    localparam int ROM_W   = 1;
    localparam int PERIF_W = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] mem_address;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        mem_read;
    logic        mem_write_en;
    logic [1:0]  mem_size;
    logic        ROM_select;
    logic        RAM_select;
    logic        PERIF_select;
    logic        UNUSED_select;
    logic        bus_error;

    mem_bus_arbiter_if cpu_if ();
    mem_bus_arbiter_if dma_if ();

    mem_bus_arbiter #(
        .RAM_WAIT   (RAM_W),
        .ROM_WAIT   (ROM_W),
        .PERIF_WAIT (PERIF_W)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .cpu           (cpu_if),
        .dma           (dma_if),
        .mem_address   (mem_address),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .mem_read      (mem_read),
        .mem_write_en  (mem_write_en),
        .mem_size      (mem_size),
        .ROM_select    (ROM_select),
        .RAM_select    (RAM_select),
        .PERIF_select  (PERIF_select),
        .UNUSED_select (UNUSED_select),
        .bus_error     (bus_error)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        is_dma;
        logic        write;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [1:0]  size;
    } txn_t;

    typedef struct {
        txn_t        t;
        int          w;
        int          ack_cyc;
        logic [63:0] rdata;
        logic        err;
        logic [3:0]  sel;
        logic        rd;
        logic        wr;
    } exp_t;

    exp_t        sb[$];
    txn_t        cpu_q[$];
    txn_t        dma_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          bus_cycles = 0;
    logic        model_last_dma = 1'b1;
    logic [63:0] model_rdata [2];

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [63:0] mem_model(input logic [31:0] a);
        if (a == 32'h1000_0010) return 64'hDEAD_BEEF_0123_4567;
        return {~a, a ^ 32'h1357_9BDF};
    endfunction

    assign mem_rdata = mem_model(mem_address);

    task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transaction-level view: region from the top nibble, then wait, strobes and error follow.
    function automatic exp_t predict(input txn_t t, input int grant_edge);
        exp_t       e;
        logic [3:0] nib;
        nib       = t.addr[31:28];
        e.t       = t;
        e.sel     = (nib == 4'h0) ? 4'b1000 : (nib == 4'h1) ? 4'b0100 :
                    (nib == 4'h2) ? 4'b0010 : 4'b0001;
        e.w       = (nib == 4'h0) ? ROM_W : (nib == 4'h1) ? RAM_W : (nib == 4'h2) ? PERIF_W : 0;
        e.rd      = !t.write && (e.sel != 4'b0001);
        e.wr      = t.write && (nib == 4'h1 || nib == 4'h2);
        e.err     = (e.sel == 4'b0001) || (nib == 4'h0 && t.write);
        e.ack_cyc = grant_edge + e.w + 2;
        e.rdata   = 64'd0;
        return e;
    endfunction

    task automatic add_txn(input logic is_dma, input logic write, input logic [31:0] addr,
                           input logic [63:0] wdata, input logic [1:0] size);
        txn_t t;
        t.is_dma = is_dma;
        t.write  = write;
        t.addr   = addr;
        t.wdata  = wdata;
        t.size   = size;
        if (is_dma) dma_q.push_back(t);
        else        cpu_q.push_back(t);
    endtask

    task automatic drive_ports();
        cpu_if.req = (cpu_q.size() != 0);
        dma_if.req = (dma_q.size() != 0);
        if (cpu_q.size() != 0) begin
            cpu_if.write = cpu_q[0].write;
            cpu_if.addr  = cpu_q[0].addr;
            cpu_if.wdata = cpu_q[0].wdata;
            cpu_if.size  = cpu_q[0].size;
        end
        if (dma_q.size() != 0) begin
            dma_if.write = dma_q[0].write;
            dma_if.addr  = dma_q[0].addr;
            dma_if.wdata = dma_q[0].wdata;
            dma_if.size  = dma_q[0].size;
        end
    endtask

    // Serve order from the priority rule; each grant is W+3 cycles after the previous one.
    task automatic plan_burst();
        txn_t mc[$];
        txn_t md[$];
        exp_t e;
        logic take_dma;
        int   t;
        mc = cpu_q;
        md = dma_q;
        t  = cyc + 1;
        while (mc.size() != 0 || md.size() != 0) begin
            if (mc.size() != 0 && md.size() != 0) begin
`ifdef ARB_ROUND_ROBIN_EN
                take_dma = !model_last_dma;
`else
                take_dma = 1'b0;
`endif
            end else begin
                take_dma = (md.size() != 0);
            end
            if (take_dma) e = predict(md.pop_front(), t);
            else          e = predict(mc.pop_front(), t);
            model_last_dma = take_dma;
            if (!e.t.write) model_rdata[take_dma] = (e.sel == 4'b0001) ? 64'd0 : mem_model(e.t.addr);
            e.rdata = model_rdata[take_dma];
            sb.push_back(e);
            t = t + e.w + 3;
        end
    endtask

    task automatic apply_stimulus();
        int budget;
        plan_burst();
        drive_ports();
        budget = 0;
        while ((cpu_q.size() != 0 || dma_q.size() != 0) && budget < 200) begin
            @(negedge clock);
            budget++;
            if (cpu_if.ack) void'(cpu_q.pop_front());
            if (dma_if.ack) void'(dma_q.pop_front());
            drive_ports();
        end
        if (budget >= 200) begin
            miscompares++;
            $display("[TB] FAIL burst_timeout: %0d txns still pending after %0d cycles",
                     cpu_q.size() + dma_q.size(), budget);
            cpu_q.delete();
            dma_q.delete();
            drive_ports();
            sb.delete();
        end
        @(negedge clock);
    endtask

    always @(negedge clock) begin : monitor
        exp_t       e;
        logic [3:0] sel;
        if (reset) begin
            sel = {ROM_select, RAM_select, PERIF_select, UNUSED_select};
            if (sel != 4'd0) begin
                if (sb.size() == 0) begin
                    check_output("bus_unexpected", 128'(sel), 128'd0);
                end else begin
                    bus_cycles++;
                    check_output("bus_drive", {sel, mem_read, mem_write_en, mem_size, mem_address},
                                 {sb[0].sel, sb[0].rd, sb[0].wr, sb[0].t.size, sb[0].t.addr});
                    if (sb[0].wr) check_output("bus_wdata", 128'(mem_wdata), 128'(sb[0].t.wdata));
                end
            end else begin
                check_output("bus_idle", {mem_read, mem_write_en, mem_size, mem_address, mem_wdata}, 128'd0);
            end
            if (cpu_if.ack || dma_if.ack) begin
                if (sb.size() == 0) begin
                    check_output("ack_unexpected", {cpu_if.ack, dma_if.ack}, 128'd0);
                end else begin
                    e = sb.pop_front();
                    check_output("ack_port", {cpu_if.ack, dma_if.ack}, e.t.is_dma ? 2'b01 : 2'b10);
                    check_output("ack_cycle", 128'(cyc), 128'(e.ack_cyc));
                    check_output("select_cycles", 128'(bus_cycles), 128'(e.w + 1));
                    check_output("bus_error", 128'(bus_error), 128'(e.err));
                    check_output("rdata", e.t.is_dma ? dma_if.rdata : cpu_if.rdata, 128'(e.rdata));
                end
                bus_cycles = 0;
            end else begin
                check_output("bus_error_idle", 128'(bus_error), 128'd0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, %0d txns outstanding", sb.size());
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          nc;
        int          nd;
        logic [3:0]  nib;
        model_rdata[0] = 64'd0;
        model_rdata[1] = 64'd0;
        cpu_if.req = 1'b0; cpu_if.write = 1'b0; cpu_if.addr = '0; cpu_if.wdata = '0; cpu_if.size = '0;
        dma_if.req = 1'b0; dma_if.write = 1'b0; dma_if.addr = '0; dma_if.wdata = '0; dma_if.size = '0;

        // Reset held with a pending CPU read: nothing may move.
        add_txn(1'b0, 1'b0, 32'h1000_0008, 64'd0, 2'd3);
        drive_ports();
        #2 reset = 1'b0;
        repeat (3) @(negedge clock);
        check_output("reset_ack", {cpu_if.ack, dma_if.ack, bus_error}, 128'd0);
        check_output("reset_rdata", {cpu_if.rdata, dma_if.rdata}, 128'd0);
        check_output("reset_bus", {ROM_select, RAM_select, PERIF_select, UNUSED_select,
                                   mem_read, mem_write_en, mem_size, mem_address, mem_wdata}, 128'd0);
        reset = 1'b1;
        apply_stimulus();

        add_txn(1'b0, 1'b0, 32'h1000_0010, 64'd0, 2'd3);
        apply_stimulus();
        add_txn(1'b1, 1'b1, 32'h2000_0000, 64'h55, 2'd0);
        apply_stimulus();

        for (int k = 0; k < 4; k++) begin
            add_txn(1'b0, 1'b0, 32'h1000_0100 + 32'(k * 8), 64'd0, 2'd3);
            add_txn(1'b1, 1'b1, 32'h1000_0200 + 32'(k * 8), 64'h1111_0000 + 64'(k), 2'd2);
        end
        apply_stimulus();

        add_txn(1'b0, 1'b1, 32'h0000_0040, 64'hCAFE, 2'd3);
        apply_stimulus();
        add_txn(1'b1, 1'b0, 32'h7000_0000, 64'd0, 2'd3);
        apply_stimulus();

        // Reset in the middle of a ROM read: strobes drop at once and no ack follows.
        add_txn(1'b0, 1'b0, 32'h0000_0100, 64'd0, 2'd3);
        plan_burst();
        drive_ports();
        @(negedge clock);
        #1 reset = 1'b0;
        #1 check_output("abort_strobes", {ROM_select, mem_read, mem_write_en, mem_address}, 128'd0);
        repeat (2) begin
            @(negedge clock);
            check_output("abort_no_ack", {cpu_if.ack, dma_if.ack}, 128'd0);
        end
        cpu_q.delete();
        drive_ports();
        sb.delete();
        bus_cycles     = 0;
        model_last_dma = 1'b1;
        model_rdata[0] = 64'd0;
        model_rdata[1] = 64'd0;
        reset = 1'b1;
        @(negedge clock);
        add_txn(1'b0, 1'b0, 32'h0000_0100, 64'd0, 2'd1);
        apply_stimulus();

        for (int i = 0; i < 40; i++) begin
            nc = $urandom_range(0, 2);
            nd = $urandom_range(0, 2);
            if (nc + nd == 0) nc = 1;
            for (int k = 0; k < nc + nd; k++) begin
                nib = 4'($urandom_range(0, 5));
                if (nib > 4'd2) nib = 4'($urandom_range(3, 15));
                add_txn(k >= nc, 1'($urandom), {nib, 28'($urandom)}, {$urandom, $urandom},
                        2'($urandom));
            end
            apply_stimulus();
        end

        if (sb.size() != 0) check_output("scoreboard_drained", 128'(sb.size()), 128'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
